// File: rtl/i2c_write_engine.sv
// rtl/i2c_write_engine.sv - write-only single-master I2C engine for the codec control bus
//
// Serialises one 24-bit frame {slave addr+W, sub addr, data} as START, three bytes each
// followed by an ACK slot, then STOP. Runs on iCLK with a quarter-bit tick enable.
//
// Ports:
//   iCLK      system clock
//   iRST_N    asynchronous active-low reset
//   iDATA     frame to send, MSB first, latched when the frame is accepted
//   iGO       transfer request (level), held until oEND is seen
//   oEND      high in DONE until iGO drops
//   oACK      1 = some ACK slot sampled high (NACK); valid while oEND=1
//   oBUSY     high from frame acceptance until return to idle
//   I2C_SCLK  SCL, push-pull
//   I2C_SDAT  SDA, open-drain (drives 0 or z)
//
// Build option: I2C_ACK_ABORT_EN - a NACK sample jumps straight to STOP, skipping the
// remaining bytes. Undefined: all three bytes are always sent.
module i2c_write_engine #(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oEND,
    output logic        oACK,
    output logic        oBUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt;
    logic          tick;
    logic [1:0]    phase, phase_nxt;
    logic [4:0]    bitcnt, bitcnt_nxt;
    logic [23:0]   shreg, shreg_nxt;
    logic          ack_err, ack_err_nxt;
    logic          scl_q, scl_nxt;
    logic          sda_low_q, sda_low_nxt;
    logic          sda_in;

    // Bus levels for a given state/quarter; returns {scl, sda_low}.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] ph,
                                             input logic msb);
        logic [1:0] r;
        r = 2'b10;
        case (st)
            S_START: r = {ph != 2'd3, ph != 2'd0};
            S_BIT:   r = {ph[1], ~msb};
            S_ACK:   r = {ph[1], 1'b0};
            S_STOP:  r = {ph != 2'd0, ~ph[1]};
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    assign tick     = (qcnt == QLAST);
    assign sda_in   = I2C_SDAT;
    assign I2C_SCLK = scl_q;
    assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;
    assign oEND     = (state == S_DONE);
    assign oACK     = (state == S_DONE) && ack_err;
    assign oBUSY    = (state != S_IDLE);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)   qcnt <= '0;
        else if (tick) qcnt <= '0;
        else           qcnt <= qcnt + 1'b1;
    end

    // Bus outputs are registered alongside the state so SCL/SDA never glitch on decode.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            bitcnt    <= 5'd0;
            shreg     <= 24'd0;
            ack_err   <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else if (tick) begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            bitcnt    <= bitcnt_nxt;
            shreg     <= shreg_nxt;
            ack_err   <= ack_err_nxt;
            scl_q     <= scl_nxt;
            sda_low_q <= sda_low_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase + 2'd1;
        bitcnt_nxt  = bitcnt;
        shreg_nxt   = shreg;
        ack_err_nxt = ack_err;
        case (state)
            S_IDLE: begin
                phase_nxt = 2'd0;
                if (iGO) begin
                    state_nxt   = S_START;
                    shreg_nxt   = iDATA;
                    ack_err_nxt = 1'b0;
                end
            end
            S_START: begin
                if (phase == 2'd3) begin
                    state_nxt  = S_BIT;
                    bitcnt_nxt = 5'd0;
                end
            end
            S_BIT: begin
                if (phase == 2'd3) begin
                    shreg_nxt = {shreg[22:0], 1'b0};
                    if (bitcnt == 5'd7 || bitcnt == 5'd15 || bitcnt == 5'd23)
                        state_nxt = S_ACK;
                    else
                        bitcnt_nxt = bitcnt + 5'd1;
                end
            end
            S_ACK: begin
                if (phase == 2'd3) begin
                    ack_err_nxt = ack_err | sda_in;
`ifdef I2C_ACK_ABORT_EN
                    if (sda_in || bitcnt == 5'd23) begin
`else
                    if (bitcnt == 5'd23) begin
`endif
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt  = S_BIT;
                        bitcnt_nxt = bitcnt + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (phase == 2'd3) state_nxt = S_DONE;
            end
            S_DONE: begin
                phase_nxt = 2'd0;
                if (!iGO) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = 2'd0;
            end
        endcase
        {scl_nxt, sda_low_nxt} = bus_drive(state_nxt, phase_nxt, shreg_nxt[23]);
    end
endmodule

// File: tb/tb_i2c_write_engine.sv
// tb/tb_i2c_write_engine.sv - scoreboard bench for i2c_write_engine
module tb_i2c_write_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data;
    logic        go;
    logic        o_end, o_ack, busy, scl;
    wire         sda;
    logic [2:0]  nack;
    logic        slave_low;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic        ack;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_write_engine #(.CLK_FREQ(16), .I2C_FREQ(1)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iGO(go),
        .oEND(o_end), .oACK(o_ack), .oBUSY(busy),
        .I2C_SCLK(scl), .I2C_SDAT(sda)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] bits, input int nbits, input logic ack, input int lat);
        exp_t e;
        e.bits = bits; e.nbits = nbits; e.ack = ack; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Monitor: decodes the bus and oEND, compares against queued expectations.
    int          cyc = 0;
    int          start_cyc = 0;
    logic        pscl = 1'b1, psda = 1'b1, pend = 1'b0;
    logic        in_frame = 1'b0, cur_v = 1'b0;
    logic [31:0] cap = '0;
    int          ncap = 0;
    exp_t        cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0;
            cur_v    = 1'b0;
        end else begin
            if (pscl && scl && psda !== sda) begin
                if (!sda && !in_frame) begin
                    check("start_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        cur   = exp_q.pop_front();
                        cur_v = 1'b1;
                    end
                    in_frame  = 1'b1;
                    cap       = '0;
                    ncap      = 0;
                    start_cyc = cyc;
                end else if (sda && in_frame) begin
                    in_frame = 1'b0;
                    if (cur_v) begin
                        check("frame_nbits", 32'(ncap - 1), 32'(cur.nbits));
                        check("frame_bits", cap >> 1, cur.bits);
                    end
                end else begin
                    check("sda_while_scl_high", {30'd0, psda, sda}, {30'd0, psda, psda});
                end
            end else if (!pscl && scl && in_frame) begin
                cap = {cap[30:0], sda};
                ncap++;
            end
            if (o_end && !pend) begin
                check("end_has_frame", 32'(cur_v), 32'd1);
                if (cur_v) begin
                    check("end_ack", 32'(o_ack), 32'(cur.ack));
                    check("end_latency", 32'(cyc - start_cyc), 32'(cur.lat));
                    cur_v = 1'b0;
                end
            end
        end
        pscl = scl;
        psda = sda;
        pend = o_end;
    end

    // Slave: counts SCL falls since START; pulls SDA low in ACK slots not marked NACK.
    int falls = 0;
    int base  = 0;
    int fc;
    always @(negedge scl) falls++;
    always @(negedge sda) if (scl && rst_n) base = falls;
    assign fc = falls - base;
    assign slave_low = in_frame && rst_n &&
                       ((fc == 9 && !nack[0]) || (fc == 18 && !nack[1]) || (fc == 27 && !nack[2]));

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!o_end && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
    endtask

    task automatic release_go(input string name);
        go = 1'b0;
        repeat (4) @(negedge clk);
        check({name, "_end_low"}, 32'(o_end), 32'd0);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; go = 1'b0; data = '0; nack = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_end", 32'(o_end), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Full frame, slave ACKs everything; then hold iGO in DONE (no auto-repeat).
        nack = 3'b000;
        push(32'(27'b001101000_000011000_100000000), 27, 1'b0, 460);
        data = 24'h340C80; go = 1'b1;
        wait_end("t1_end_seen");
        check("t1_busy_in_done", 32'(busy), 32'd1);
        repeat (800) @(negedge clk);
        check("t3_end_held", 32'(o_end), 32'd1);
        release_go("t3");

        // NACK on byte 2.
        nack = 3'b010;
`ifdef I2C_ACK_ABORT_EN
        push(32'(18'b101001010_001111001), 18, 1'b1, 316);
`else
        push(32'(27'b101001010_001111001_111100000), 27, 1'b1, 460);
`endif
        data = 24'hA53CF0; go = 1'b1;
        wait_end("t2_end_seen");
        release_go("t2");

        // iGO dropped and iDATA changed mid-frame.
        nack = 3'b000;
        push(32'(27'b000100100_111111110_000000010), 27, 1'b0, 460);
        data = 24'h12FF01; go = 1'b1;
        repeat (160) @(negedge clk);
        go = 1'b0; data = 24'hFFFFFF;
        wait_end("t4_end_seen");
        n = 0;
        while (o_end && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_end_width", 32'(n), 32'd4);
        check("t4_busy_low", 32'(busy), 32'd0);

        // Reset mid-frame.
        push(32'(27'b010101010_101010100_000011110), 27, 1'b0, 460);
        data = 24'h55AA0F; go = 1'b1;
        repeat (240) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_scl", 32'(scl), 32'd1);
        check("t5_sda", 32'(sda), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_end", 32'(o_end), 32'd0);
        check("t5_ack", 32'(o_ack), 32'd0);
        go = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Frame after reset, slave NACKs byte 1.
        nack = 3'b001;
`ifdef I2C_ACK_ABORT_EN
        push(32'(9'b001101001), 9, 1'b1, 172);
`else
        push(32'(27'b001101001_000011000_100000000), 27, 1'b1, 460);
`endif
        data = 24'h340C80; go = 1'b1;
        wait_end("t6_end_seen");
        release_go("t6");

        repeat (20) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
